// File: rtl/pulse_sync_scheduler.sv
// Sending-domain scheduler that shares one toggle pulse synchronizer among NUM_REQ
// requesters: per-requester pending counters, round-robin grant and minimum pulse spacing.
module pulse_sync_scheduler #(
  parameter  int NUM_REQ = 4,
  parameter  int CNT_W   = 3,
  parameter  int GAP     = 4,
  localparam int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic               clock_a,
  input  logic               async_rst_n,
  input  logic               en,
  input  logic [NUM_REQ-1:0] req_pls,
  input  logic [NUM_REQ-1:0] clr_ovf,
  output logic               pls_a,
  output logic [ID_W-1:0]    pls_id,
  output logic               busy,
  output logic               pend_any,
  output logic [NUM_REQ-1:0] ovf_flag
);

  localparam int               GAP_W   = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [GAP_W-1:0] GAP_LD  = GAP_W'(GAP - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_HOLDOFF
  } state_e;

  state_e             state_q, state_d;
  logic [GAP_W-1:0]   gap_q, gap_d;
  logic [ID_W-1:0]    rr_ptr_q;
  logic [CNT_W-1:0]   cnt_q [NUM_REQ];
  logic [CNT_W-1:0]   cnt_d [NUM_REQ];
  logic [NUM_REQ-1:0] dec_vec;
  logic [NUM_REQ-1:0] ovf_d;
  logic               pend_d;
  logic               win_found;
  logic [ID_W-1:0]    win_id;
  logic               grant;

  // Round-robin search starting just after the last granted requester.
  always_comb begin
    int              idx;
    logic [ID_W-1:0] cand;
    win_found = 1'b0;
    win_id    = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx  = (int'(rr_ptr_q) + k) % NUM_REQ;
      cand = ID_W'(idx);
      if (!win_found && (cnt_q[cand] != '0)) begin
        win_found = 1'b1;
        win_id    = cand;
      end
    end
  end

  // NOTE: every signal written in an always_comb gets a default first, so no path
  // through the block leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    grant   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (en && win_found) begin
          grant   = 1'b1;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        gap_d   = GAP_LD;
        state_d = S_HOLDOFF;
      end
      S_HOLDOFF: begin
        if (gap_q == '0) state_d = S_IDLE;
        else             gap_d   = gap_q - GAP_W'(1);
      end
      default: state_d = S_IDLE;
    endcase
  end

  // A request that coincides with its own decrement cancels out, so it can never overflow.
  always_comb begin
    dec_vec = '0;
    cnt_d   = cnt_q;
    ovf_d   = ovf_flag & ~clr_ovf;
    pend_d  = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      dec_vec[i] = (state_q == S_ISSUE) && (pls_id == ID_W'(i));
      if (req_pls[i] && !dec_vec[i]) begin
        if (cnt_q[i] == CNT_MAX) ovf_d[i] = 1'b1;
        else                     cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end else if (dec_vec[i] && !req_pls[i]) begin
        cnt_d[i] = cnt_q[i] - CNT_W'(1);
      end
      pend_d = pend_d | (cnt_d[i] != '0);
    end
  end

  // NOTE: the pending counters are a handful of flops rather than a RAM, so they are
  // reset like any other register; reset must discard all queued work.
  always_ff @(posedge clock_a or negedge async_rst_n) begin
    if (!async_rst_n) begin
      state_q  <= S_IDLE;
      gap_q    <= '0;
      rr_ptr_q <= ID_W'(NUM_REQ - 1);
      pls_a    <= 1'b0;
      pls_id   <= '0;
      busy     <= 1'b0;
      pend_any <= 1'b0;
      ovf_flag <= '0;
      for (int i = 0; i < NUM_REQ; i++) cnt_q[i] <= '0;
    end else begin
      // NOTE: all state updates are non-blocking so every flop samples pre-edge values.
      state_q  <= state_d;
      gap_q    <= gap_d;
      pls_a    <= (state_d == S_ISSUE);
      busy     <= (state_d != S_IDLE);
      pend_any <= pend_d;
      ovf_flag <= ovf_d;
      cnt_q    <= cnt_d;
      if (grant)              pls_id   <= win_id;
      if (state_q == S_ISSUE) rr_ptr_q <= pls_id;
    end
  end

endmodule

// File: tb/tb_pulse_sync_scheduler.sv
// Self-checking bench for pulse_sync_scheduler: directed table, corner-case sequences
// and randomized traffic against a timeline-based reference model.
module tb_pulse_sync_scheduler;

  localparam int NUM_REQ = 4;
  localparam int CNT_W   = 3;
  localparam int GAP     = 4;
  localparam int ID_W    = 2;
  localparam int CMAX    = (1 << CNT_W) - 1;

  logic               clk = 1'b0;
  logic               async_rst_n = 1'b0;
  logic               en = 1'b0;
  logic [NUM_REQ-1:0] req_pls = '0;
  logic [NUM_REQ-1:0] clr_ovf = '0;
  logic               pls_a;
  logic [ID_W-1:0]    pls_id;
  logic               busy;
  logic               pend_any;
  logic [NUM_REQ-1:0] ovf_flag;

  pulse_sync_scheduler #(.NUM_REQ(NUM_REQ), .CNT_W(CNT_W), .GAP(GAP)) dut (
    .clock_a     (clk),
    .async_rst_n (async_rst_n),
    .en          (en),
    .req_pls     (req_pls),
    .clr_ovf     (clr_ovf),
    .pls_a       (pls_a),
    .pls_id      (pls_id),
    .busy        (busy),
    .pend_any    (pend_any),
    .ovf_flag    (ovf_flag)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: pending counts, sticky flags and the cycle of the last pulse.
  int               m_cnt [NUM_REQ];
  logic [NUM_REQ-1:0] m_ovf;
  int               m_ptr, m_last, m_id, m_cyc;
  logic             m_pls, m_busy, m_pend;

  int pulse_cyc[$];
  int pulse_id[$];

  typedef struct {
    logic               en;
    logic [NUM_REQ-1:0] req;
    logic [NUM_REQ-1:0] clr;
    logic               exp_pls;
    logic [ID_W-1:0]    exp_id;
    logic               exp_busy;
    logic               exp_pend;
  } vec_t;

  vec_t tbl [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, m_cyc);
  endtask

  function automatic void model_reset();
    for (int i = 0; i < NUM_REQ; i++) m_cnt[i] = 0;
    m_ovf  = '0;
    m_ptr  = NUM_REQ - 1;
    m_last = -1000;
    m_id   = 0;
    m_cyc  = 0;
    m_pls  = 1'b0;
    m_busy = 1'b0;
    m_pend = 1'b0;
  endfunction

  // Advance the model across one clock edge using the inputs currently applied.
  function automatic void model_step();
    int  n        = m_cyc + 1;
    bit  issuing  = m_pls;
    int  iss_id   = m_id;
    bit  idle     = (m_cyc > m_last + GAP);
    bit  any      = 1'b0;
    bit  granted  = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) if (m_cnt[i] != 0) any = 1'b1;
    if (idle && en && any) begin
      for (int k = 1; k <= NUM_REQ; k++) begin
        int w = (m_ptr + k) % NUM_REQ;
        if (!granted && m_cnt[w] != 0) begin
          granted = 1'b1;
          m_id    = w;
        end
      end
      m_ptr  = m_id;
      m_last = n;
    end
    m_pls = granted;
    for (int i = 0; i < NUM_REQ; i++) begin
      bit dec = issuing && (iss_id == i);
      if (clr_ovf[i]) m_ovf[i] = 1'b0;
      if (req_pls[i] && !dec) begin
        if (m_cnt[i] == CMAX) m_ovf[i] = 1'b1;
        else m_cnt[i]++;
      end else if (dec && !req_pls[i]) begin
        m_cnt[i]--;
      end
    end
    m_busy = (n >= m_last) && (n <= m_last + GAP);
    m_pend = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) if (m_cnt[i] != 0) m_pend = 1'b1;
    m_cyc = n;
  endfunction

  task automatic tick();
    logic [31:0] exp_v;
    model_step();
    @(posedge clk);
    #1;
    exp_v = {23'd0, m_pls, ID_W'(m_id), m_busy, m_pend, m_ovf};
    check("cycle_outputs", {23'd0, pls_a, pls_id, busy, pend_any, ovf_flag}, exp_v);
    if (pls_a) begin
      pulse_cyc.push_back(m_cyc);
      pulse_id.push_back(int'(pls_id));
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset();
    async_rst_n = 1'b0;
    en          = 1'b0;
    req_pls     = '0;
    clr_ovf     = '0;
    #1;
    check("reset_outputs", {23'd0, pls_a, pls_id, busy, pend_any, ovf_flag}, 32'd0);
    @(posedge clk);
    @(posedge clk);
    #2;
    async_rst_n = 1'b1;
    model_reset();
    pulse_cyc.delete();
    pulse_id.delete();
  endtask

  task automatic pulse_req(input logic [NUM_REQ-1:0] r);
    req_pls = r;
    tick();
    req_pls = '0;
  endtask

  initial begin
    int seen;
    model_reset();

    // Single request: latency, id and busy length.
    tbl[0] = '{1'b1, 4'b0001, 4'b0000, 1'b0, 2'd0, 1'b0, 1'b1};
    tbl[1] = '{1'b1, 4'b0000, 4'b1010, 1'b1, 2'd0, 1'b1, 1'b1};
    tbl[2] = '{1'b1, 4'b0000, 4'b0000, 1'b0, 2'd0, 1'b1, 1'b0};
    tbl[3] = '{1'b1, 4'b0000, 4'b0000, 1'b0, 2'd0, 1'b1, 1'b0};
    tbl[4] = '{1'b1, 4'b0000, 4'b0000, 1'b0, 2'd0, 1'b1, 1'b0};
    tbl[5] = '{1'b1, 4'b0000, 4'b0000, 1'b0, 2'd0, 1'b1, 1'b0};
    tbl[6] = '{1'b1, 4'b0000, 4'b0000, 1'b0, 2'd0, 1'b0, 1'b0};
    tbl[7] = '{1'b0, 4'b0000, 4'b0000, 1'b0, 2'd0, 1'b0, 1'b0};

    do_reset();
    for (int v = 0; v < 8; v++) begin
      en      = tbl[v].en;
      req_pls = tbl[v].req;
      clr_ovf = tbl[v].clr;
      tick();
      check($sformatf("table_row%0d", v), {28'd0, pls_a, pls_id, busy, pend_any},
            {28'd0, tbl[v].exp_pls, tbl[v].exp_id, tbl[v].exp_busy, tbl[v].exp_pend});
    end
    req_pls = '0;
    clr_ovf = '0;

    // All four requesters at once: ids 0..3, GAP+2 apart.
    do_reset();
    en = 1'b1;
    pulse_req(4'b1111);
    run(30);
    check("burst_count", pulse_id.size(), 4);
    for (int k = 0; k < 4 && k < pulse_id.size(); k++) begin
      check($sformatf("burst_id%0d", k), pulse_id[k], k);
      if (k > 0) check($sformatf("burst_gap%0d", k), pulse_cyc[k] - pulse_cyc[k-1], GAP + 2);
    end
    check("burst_pend_drop", pend_any, 1'b0);

    // Saturation of requester 2 while disabled, then drain.
    do_reset();
    en = 1'b0;
    for (int k = 0; k < 9; k++) pulse_req(4'b0100);
    check("sat_ovf_set", ovf_flag, 4'b0100);
    en = 1'b1;
    run(55);
    check("sat_pulses", pulse_id.size(), 7);
    seen = 0;
    foreach (pulse_id[k]) if (pulse_id[k] == 2) seen++;
    check("sat_ids", seen, 7);
    clr_ovf = 4'b0100;
    tick();
    clr_ovf = '0;
    check("sat_ovf_clr", ovf_flag, 4'b0000);

    // Request during own ISSUE at cnt=7: no overflow, extra pulse later.
    do_reset();
    en = 1'b0;
    for (int k = 0; k < 7; k++) pulse_req(4'b0010);
    en   = 1'b1;
    seen = 0;
    for (int k = 0; k < 10 && !seen; k++) begin
      tick();
      if (pls_a) seen = 1;
    end
    check("issue_seen", seen, 1);
    pulse_req(4'b0010);
    check("issue_no_ovf", ovf_flag, 4'b0000);
    run(60);
    check("issue_pulses", pulse_id.size(), 8);

    // en low holds pending work; resume continues after last granted id.
    do_reset();
    en = 1'b1;
    pulse_req(4'b0010);
    run(10);
    en = 1'b0;
    pulse_req(4'b1111);
    run(8);
    check("hold_state", {29'd0, pls_a, busy, pend_any}, 32'b001);
    pulse_cyc.delete();
    pulse_id.delete();
    en = 1'b1;
    run(30);
    check("resume_count", pulse_id.size(), 4);
    for (int k = 0; k < 4 && k < pulse_id.size(); k++)
      check($sformatf("resume_id%0d", k), pulse_id[k], (2 + k) % NUM_REQ);

    // Asynchronous reset during HOLDOFF discards pending work.
    do_reset();
    en = 1'b1;
    pulse_req(4'b1111);
    seen = 0;
    for (int k = 0; k < 10 && !seen; k++) begin
      tick();
      if (pls_a) seen = 1;
    end
    check("pre_reset_pulse", seen, 1);
    run(2);
    check("pre_reset_busy", {30'd0, busy, pend_any}, 32'b11);
    do_reset();
    en = 1'b1;
    run(20);
    check("post_reset_quiet", pulse_id.size(), 0);

    // Randomized traffic against the model.
    do_reset();
    for (int c = 0; c < 800; c++) begin
      en = ($urandom_range(0, 9) != 0);
      for (int i = 0; i < NUM_REQ; i++) begin
        req_pls[i] = ($urandom_range(0, 6) == 0);
        clr_ovf[i] = ($urandom_range(0, 19) == 0);
      end
      tick();
    end
    req_pls = '0;
    clr_ovf = '0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
